// File: rtl/twenty_bit_divider_pkg.sv
// twenty_bit_divider_pkg: shared widths, state encodings and divide-by-zero quotient
package twenty_bit_divider_pkg;
  localparam int WIDTH = 20;
  localparam int ITER_W = 5;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN = 2'd1;
  localparam logic [1:0] S_ZERO = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;
  localparam logic [WIDTH-1:0] DZ_QUOTIENT = 20'hFFFFF;
  localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(WIDTH - 1);
endpackage

// File: rtl/twenty_bit_divider_if.sv
// twenty_bit_divider_if: start/busy/done handshake and operand/result bus
interface twenty_bit_divider_if;
  import twenty_bit_divider_pkg::*;
  logic start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic busy;
  logic done;
  logic div_by_zero;
  modport master(output start, dividend, divisor, input quotient, remainder, busy, done, div_by_zero);
  modport slave(input start, dividend, divisor, output quotient, remainder, busy, done, div_by_zero);
endinterface

// File: rtl/twenty_bit_subtractor.sv
// twenty_bit_subtractor: combinational unsigned a - b with borrow-out
module twenty_bit_subtractor
  import twenty_bit_divider_pkg::*;
(
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);
  assign {bout, diff} = {1'b0, a} - {1'b0, b};
endmodule

// File: rtl/twenty_bit_divider.sv
// twenty_bit_divider: iterative unsigned restoring divider, one quotient bit per cycle
module twenty_bit_divider
  import twenty_bit_divider_pkg::*;
(
  input logic clk,
  input logic rst,
  twenty_bit_divider_if.slave bus
);
  logic [1:0] state_q, state_d;
  logic [ITER_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] r_q, r_d, q_q, q_d, d_q, d_d, quo_q, quo_d, rem_q, rem_d;
  logic dz_q, dz_d;
  logic [WIDTH:0] s;
  logic [WIDTH-1:0] diff;
  logic bout, acc, accept;
  assign s = {r_q, q_q[WIDTH-1]};
  twenty_bit_subtractor u_sub (.a(s[WIDTH-1:0]), .b(d_q), .diff(diff), .bout(bout));
  // s[WIDTH] set means the shifted remainder already exceeds any 20-bit divisor
  assign acc = s[WIDTH] | ~bout;
  assign accept = bus.start && (state_q == S_IDLE || state_q == S_DONE);
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    r_d = r_q;
    q_d = q_q;
    d_d = d_q;
    quo_d = quo_q;
    rem_d = rem_q;
    dz_d = dz_q;
    if (accept) begin
      state_d = (bus.divisor == '0) ? S_ZERO : S_RUN;
      cnt_d = '0;
      r_d = '0;
      q_d = bus.dividend;
      d_d = bus.divisor;
      dz_d = 1'b0;
    end else if (state_q == S_RUN) begin
      r_d = acc ? diff : s[WIDTH-1:0];
      q_d = {q_q[WIDTH-2:0], acc};
      cnt_d = cnt_q + 1'b1;
      state_d = (cnt_q == LAST_ITER) ? S_DONE : S_RUN;
      quo_d = (cnt_q == LAST_ITER) ? q_d : quo_q;
      rem_d = (cnt_q == LAST_ITER) ? r_d : rem_q;
    end else if (state_q == S_ZERO) begin
      state_d = S_DONE;
      quo_d = DZ_QUOTIENT;
      rem_d = q_q;
      dz_d = 1'b1;
    end else if (state_q == S_DONE) begin
      state_d = S_IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      r_q <= '0;
      q_q <= '0;
      d_q <= '0;
      quo_q <= '0;
      rem_q <= '0;
      dz_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      r_q <= r_d;
      q_q <= q_d;
      d_q <= d_d;
      quo_q <= quo_d;
      rem_q <= rem_d;
      dz_q <= dz_d;
    end
  end
  assign bus.quotient = quo_q;
  assign bus.remainder = rem_q;
  assign bus.busy = (state_q == S_RUN);
  assign bus.done = (state_q == S_DONE);
  assign bus.div_by_zero = dz_q;
endmodule
